// File: rtl/fir_axil_pkg.sv
// Shared definitions for the FIR AXI-Lite host: target register map, ap_ctrl bits, FSM states.
package fir_axil_pkg;

  localparam int unsigned ADDR_AP_CTRL  = 32'h00;
  localparam int unsigned ADDR_DATA_LEN = 32'h10;
  localparam int unsigned ADDR_TAP_BASE = 32'h20;

  localparam int unsigned AP_START = 0;
  localparam int unsigned AP_DONE  = 1;
  localparam int unsigned AP_IDLE  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWrLen,
    StWrTap,
    StRdTap,
    StWrStart,
    StPollGap,
    StPollRd,
    StFinish
  } host_state_e;

  typedef enum logic [1:0] {
    XactIdle,
    XactWrite,
    XactRdAddr,
    XactRdData
  } xact_state_e;

endpackage

// File: rtl/axil_master_xact.sv
// Single AXI-Lite master transaction engine: one write (AW+W, no B) or one read per req,
// answered by a one-cycle ack after the last handshake.
module axil_master_xact
  import fir_axil_pkg::*;
#(
  parameter int unsigned AddrWidth = 12,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 axis_clk,
  input  logic                 axis_rst,
  input  logic                 req,
  input  logic                 req_write,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 ack,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 awvalid,
  output logic [AddrWidth-1:0] awaddr,
  input  logic                 awready,
  output logic                 wvalid,
  output logic [DataWidth-1:0] wdata,
  input  logic                 wready,
  output logic                 arvalid,
  output logic [AddrWidth-1:0] araddr,
  input  logic                 arready,
  input  logic                 rvalid,
  input  logic [DataWidth-1:0] rdata,
  output logic                 rready
);

  xact_state_e          state_q, state_d;
  logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                 arvalid_q, arvalid_d, rready_q, rready_d;
  logic                 ack_q, ack_d;
  logic [AddrWidth-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    araddr_d  = araddr_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    unique case (state_q)
      XactIdle: begin
        if (req) begin
          if (req_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = req_addr;
            wdata_d   = req_wdata;
            state_d   = XactWrite;
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = req_addr;
            state_d   = XactRdAddr;
          end
        end
      end
      XactWrite: begin
        // AW and W retire independently; the write is done once both have.
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          ack_d   = 1'b1;
          state_d = XactIdle;
        end
      end
      XactRdAddr: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = XactRdData;
        end
      end
      XactRdData: begin
        if (rvalid) begin
          rready_d = 1'b0;
          rdata_d  = rdata;
          ack_d    = 1'b1;
          state_d  = XactIdle;
        end
      end
      default: state_d = XactIdle;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q   <= XactIdle;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_rdata = rdata_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rready    = rready_q;

endmodule

// File: rtl/fir_axil_host.sv
// Job sequencer for the FIR accelerator: programs length and taps, optionally verifies the
// taps, starts the core and polls ap_ctrl until done or timeout.
module fir_axil_host
  import fir_axil_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH  = 12,
  parameter int unsigned pDATA_WIDTH  = 32,
  parameter int unsigned Tape_Num     = 11,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned POLL_TIMEOUT = 4096
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   coef_we,
  input  logic [3:0]             coef_idx,
  input  logic [pDATA_WIDTH-1:0] coef_wdata,
  input  logic [pDATA_WIDTH-1:0] job_len,
  input  logic                   job_verify,
  input  logic                   job_start,
  output logic                   busy,
  output logic                   done,
  output logic                   err_mismatch,
  output logic                   err_timeout,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);

  localparam int unsigned PollW   = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned GapLast = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;
  localparam int unsigned GapW    = (GapLast > 0) ? $clog2(GapLast + 1) : 1;
  localparam logic [3:0]       LastIdx = 4'(Tape_Num - 1);
  localparam logic [PollW-1:0] PollMax = PollW'(POLL_TIMEOUT);
  localparam logic [GapW-1:0]  GapMax  = GapW'(GapLast);
  localparam host_state_e      AfterPoll = (POLL_GAP == 0) ? StPollRd : StPollGap;

  host_state_e            state_q, state_d;
  logic [3:0]             idx_q, idx_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic                   verify_q, verify_d;
  logic [PollW-1:0]       poll_cnt_q, poll_cnt_d;
  logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;
  logic                   issued_q, issued_d;
  logic                   err_mismatch_q, err_mismatch_d, err_timeout_q, err_timeout_d;
  logic [pDATA_WIDTH-1:0] coef_q [Tape_Num];

  logic                   req, req_write, ack;
  logic [pADDR_WIDTH-1:0] req_addr, tap_addr;
  logic [pDATA_WIDTH-1:0] req_wdata, rsp_rdata, coef_cur;
  logic                   bus_state;

  // Not reset: coefficients survive a host reset.
  always_ff @(posedge axis_clk) begin
    if (coef_we && (coef_idx <= LastIdx)) begin
      coef_q[coef_idx] <= coef_wdata;
    end
  end

  assign tap_addr = pADDR_WIDTH'(ADDR_TAP_BASE) + pADDR_WIDTH'({idx_q, 2'b00});
  assign coef_cur = coef_q[idx_q];

  always_comb begin
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    bus_state = 1'b1;
    case (state_q)
      StWrLen: begin
        req_write = 1'b1;
        req_addr  = pADDR_WIDTH'(ADDR_DATA_LEN);
        req_wdata = len_q;
      end
      StWrTap: begin
        req_write = 1'b1;
        req_addr  = tap_addr;
        req_wdata = coef_cur;
      end
      StRdTap:  req_addr = tap_addr;
      StWrStart: begin
        req_write            = 1'b1;
        req_addr             = pADDR_WIDTH'(ADDR_AP_CTRL);
        req_wdata[AP_START]  = 1'b1;
      end
      StPollRd: req_addr = pADDR_WIDTH'(ADDR_AP_CTRL);
      default:  bus_state = 1'b0;
    endcase
    // One request per bus state visit; issued_q holds it off until the ack arrives.
    req = bus_state && !issued_q;
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    verify_d       = verify_q;
    poll_cnt_d     = poll_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    err_mismatch_d = err_mismatch_q;
    err_timeout_d  = err_timeout_q;
    issued_d       = (issued_q | req) & ~ack;
    unique case (state_q)
      StIdle: begin
        if (job_start) begin
          len_d          = job_len;
          verify_d       = job_verify;
          err_mismatch_d = 1'b0;
          err_timeout_d  = 1'b0;
          idx_d          = '0;
          state_d        = StWrLen;
        end
      end
      StWrLen: if (ack) state_d = StWrTap;
      StWrTap: begin
        if (ack) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = verify_q ? StRdTap : StWrStart;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StRdTap: begin
        if (ack) begin
          if (rsp_rdata != coef_cur) err_mismatch_d = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StWrStart;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      StWrStart: begin
        if (ack) begin
          poll_cnt_d = '0;
          gap_cnt_d  = '0;
          state_d    = AfterPoll;
        end
      end
      StPollGap: begin
        if (gap_cnt_q == GapMax) begin
          gap_cnt_d = '0;
          state_d   = StPollRd;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      StPollRd: begin
        if (ack) begin
          if (poll_cnt_q != PollMax) poll_cnt_d = poll_cnt_q + 1'b1;
          if (rsp_rdata[AP_DONE]) begin
            state_d = StFinish;
          end else if (poll_cnt_d == PollMax) begin
            err_timeout_d = 1'b1;
            state_d       = StFinish;
          end else begin
            state_d = AfterPoll;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      len_q          <= '0;
      verify_q       <= 1'b0;
      poll_cnt_q     <= '0;
      gap_cnt_q      <= '0;
      issued_q       <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      verify_q       <= verify_d;
      poll_cnt_q     <= poll_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      issued_q       <= issued_d;
      err_mismatch_q <= err_mismatch_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign busy         = (state_q != StIdle) && (state_q != StFinish);
  assign done         = (state_q == StFinish);
  assign err_mismatch = err_mismatch_q;
  assign err_timeout  = err_timeout_q;

  axil_master_xact #(
    .AddrWidth (pADDR_WIDTH),
    .DataWidth (pDATA_WIDTH)
  ) u_xact (
    .axis_clk  (axis_clk),
    .axis_rst  (axis_rst),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .ack       (ack),
    .rsp_rdata (rsp_rdata),
    .awvalid   (awvalid),
    .awaddr    (awaddr),
    .awready   (awready),
    .wvalid    (wvalid),
    .wdata     (wdata),
    .wready    (wready),
    .arvalid   (arvalid),
    .araddr    (araddr),
    .arready   (arready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rready    (rready)
  );

endmodule

// File: tb/tb_fir_axil_host.sv
// Bench for fir_axil_host: AXI-Lite slave model with per-write stalls, write/read scoreboards
// filled per job, and a table of job vectors plus a mid-job reset sequence.
module tb_fir_axil_host;
  import fir_axil_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned NT = 11;
  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 8;

  logic          axis_clk = 1'b0;
  logic          axis_rst;
  logic          coef_we;
  logic [3:0]    coef_idx;
  logic [DW-1:0] coef_wdata, job_len;
  logic          job_verify, job_start;
  logic          busy, done, err_mismatch, err_timeout;
  logic          awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;

  always #5 axis_clk = ~axis_clk;

  fir_axil_host #(
    .pADDR_WIDTH  (AW),
    .pDATA_WIDTH  (DW),
    .Tape_Num     (NT),
    .POLL_GAP     (GAP),
    .POLL_TIMEOUT (TMO)
  ) dut (
    .axis_clk     (axis_clk),
    .axis_rst     (axis_rst),
    .coef_we      (coef_we),
    .coef_idx     (coef_idx),
    .coef_wdata   (coef_wdata),
    .job_len      (job_len),
    .job_verify   (job_verify),
    .job_start    (job_start),
    .busy         (busy),
    .done         (done),
    .err_mismatch (err_mismatch),
    .err_timeout  (err_timeout),
    .awvalid      (awvalid),
    .awaddr       (awaddr),
    .awready      (awready),
    .wvalid       (wvalid),
    .wdata        (wdata),
    .wready       (wready),
    .arvalid      (arvalid),
    .araddr       (araddr),
    .arready      (arready),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .rready       (rready)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int len;
    bit verify;
    int done_poll;  // poll number that returns ap_done; 0 = never
    int corrupt;    // tap index returned corrupted on readback; 15 = none
    int hs;         // 1 = skewed AW/W handshakes on the first taps
    bit poke;       // inject job_start and an out-of-range coef write mid-job
    bit exp_mis;
    bit exp_to;
  } job_vec_t;

  int n_checks = 0;
  int n_errors = 0;

  wr_t         exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] coef_model[NT];
  logic [31:0] tap_mem[16];

  int cfg_done_poll = 0, cfg_corrupt = 15, cfg_hs = 0;
  bit new_job = 1'b0;

  // Slave-model state
  logic          aw_seen, w_seen, ar_seen, rr_seen;
  logic [AW-1:0] aw_addr_seen, ar_addr_seen;
  logic [DW-1:0] w_data_seen;
  logic [31:0]   cap_addr, cap_data;
  bit            aw_got, w_got, wr_active, reissue;
  int            aw_wait, w_wait, wr_idx, polls_seen;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic int aw_delay(int hs, int idx);
    if (hs == 1 && idx == 2) return 2;
    if (hs == 1 && idx == 3) return 1;
    return 0;
  endfunction

  function automatic int w_delay(int hs, int idx);
    if (hs == 1 && idx == 1) return 3;
    if (hs == 1 && idx == 3) return 1;
    return 0;
  endfunction

  function automatic void complete_write();
    wr_t e;
    int  ti;
    chk("wr_reissue", 32'(reissue), 32'd0);
    chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
    if (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      chk("wr_addr", cap_addr, e.addr);
      chk("wr_data", cap_data, e.data);
    end
    if (cap_addr >= 32'h20 && cap_addr < 32'h60) begin
      ti = int'((cap_addr - 32'h20) >> 2);
      tap_mem[ti] = cap_data;
    end
    aw_got = 1'b0;
    w_got = 1'b0;
    aw_wait = 0;
    w_wait = 0;
    wr_active = 1'b0;
    reissue = 1'b0;
    wr_idx++;
  endfunction

  function automatic logic [31:0] read_resp(logic [31:0] a);
    int ti;
    if (a == 32'h0) begin
      polls_seen++;
      return (cfg_done_poll != 0 && polls_seen == cfg_done_poll) ? 32'h6 : 32'h0;
    end
    ti = int'((a - 32'h20) >> 2);
    if (ti < 0 || ti > 15) return 32'h0;
    if (ti == cfg_corrupt) return 32'h0000_DEAD;
    return tap_mem[ti];
  endfunction

  // Slave: resolves last edge's handshakes at the falling edge, then drives readies for the next.
  initial begin : slave
    awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
    aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0; rr_seen = 1'b0;
    aw_got = 1'b0; w_got = 1'b0; wr_active = 1'b0; reissue = 1'b0;
    aw_wait = 0; w_wait = 0; wr_idx = 0; polls_seen = 0;
    forever begin
      @(negedge axis_clk);
      if (axis_rst) begin
        awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0;
        aw_seen = 1'b0; w_seen = 1'b0; ar_seen = 1'b0; rr_seen = 1'b0;
        aw_got = 1'b0; w_got = 1'b0; wr_active = 1'b0; reissue = 1'b0;
        aw_wait = 0; w_wait = 0;
      end else begin
        if (new_job) begin
          wr_idx = 0;
          polls_seen = 0;
        end
        if (awready && aw_seen) begin aw_got = 1'b1; cap_addr = 32'(aw_addr_seen); end
        if (wready && w_seen) begin w_got = 1'b1; cap_data = w_data_seen; end
        if (aw_got && w_got) complete_write();
        if (rvalid && rr_seen) rvalid = 1'b0;
        if (arready && ar_seen) begin
          chk("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
          if (exp_rd.size() > 0) chk("rd_addr", 32'(ar_addr_seen), exp_rd.pop_front());
          rvalid = 1'b1;
          rdata = read_resp(32'(ar_addr_seen));
        end
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        if ((awvalid || wvalid) && !wr_active) begin
          wr_active = 1'b1;
          chk("aw_w_together", 32'(awvalid && wvalid), 32'd1);
        end
        if (awvalid) begin
          if (aw_got) reissue = 1'b1;
          else if (aw_wait >= aw_delay(cfg_hs, wr_idx)) awready = 1'b1;
          else aw_wait++;
        end
        if (wvalid) begin
          if (w_got) reissue = 1'b1;
          else if (w_wait >= w_delay(cfg_hs, wr_idx)) wready = 1'b1;
          else w_wait++;
        end
        if (arvalid) arready = 1'b1;
        aw_seen = awvalid; aw_addr_seen = awaddr;
        w_seen = wvalid; w_data_seen = wdata;
        ar_seen = arvalid; ar_addr_seen = araddr;
        rr_seen = rready;
      end
    end
  end

  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask

  task automatic push_job(int len, bit verify, int polls);
    exp_wr.delete();
    exp_rd.delete();
    exp_wr.push_back('{32'h10, 32'(len)});
    for (int i = 0; i < NT; i++) exp_wr.push_back('{32'h20 + 32'(4 * i), coef_model[i]});
    if (verify) for (int i = 0; i < NT; i++) exp_rd.push_back(32'h20 + 32'(4 * i));
    exp_wr.push_back('{32'h0, 32'h1});
    for (int p = 0; p < polls; p++) exp_rd.push_back(32'h0);
  endtask

  task automatic start_job(job_vec_t v);
    int polls;
    polls = (v.done_poll != 0) ? v.done_poll : int'(TMO);
    push_job(v.len, v.verify, polls);
    cfg_done_poll = v.done_poll;
    cfg_corrupt = v.corrupt;
    cfg_hs = v.hs;
    new_job = 1'b1;
    job_len = 32'(v.len);
    job_verify = v.verify;
    job_start = 1'b1;
    tick();
    job_start = 1'b0;
    new_job = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_mis_cleared", 32'(err_mismatch), 32'd0);
    chk("err_to_cleared", 32'(err_timeout), 32'd0);
  endtask

  task automatic run_job(job_vec_t v);
    int waited;
    int polls;
    polls = (v.done_poll != 0) ? v.done_poll : int'(TMO);
    start_job(v);
    if (v.poke) begin
      repeat (3) tick();
      job_start = 1'b1; job_len = 32'd999; job_verify = 1'b1;
      coef_we = 1'b1; coef_idx = 4'd12; coef_wdata = 32'h1234;
      tick();
      job_start = 1'b0; coef_we = 1'b0;
      chk("busy_after_poke", 32'(busy), 32'd1);
    end
    waited = 0;
    while (done !== 1'b1 && waited < 3000) begin
      tick();
      waited++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("err_mismatch", 32'(err_mismatch), 32'(v.exp_mis));
    chk("err_timeout", 32'(err_timeout), 32'(v.exp_to));
    chk("polls_seen", 32'(polls_seen), 32'(polls));
    chk("wr_left", 32'(exp_wr.size()), 32'd0);
    chk("rd_left", 32'(exp_rd.size()), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("sticky_mis", 32'(err_mismatch), 32'(v.exp_mis));
    chk("sticky_to", 32'(err_timeout), 32'(v.exp_to));
  endtask

  initial begin : main
    job_vec_t vecs[6];
    job_vec_t v;
    int waited;

    axis_rst = 1'b1;
    coef_we = 1'b0; coef_idx = '0; coef_wdata = '0;
    job_len = '0; job_verify = 1'b0; job_start = 1'b0;
    repeat (3) tick();
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err_mis", 32'(err_mismatch), 32'd0);
    chk("rst_err_to", 32'(err_timeout), 32'd0);
    chk("rst_awaddr", 32'(awaddr), 32'd0);
    chk("rst_araddr", 32'(araddr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    axis_rst = 1'b0;

    for (int i = 0; i < int'(NT); i++) begin
      coef_model[i] = 32'(i - 5);
      coef_we = 1'b1;
      coef_idx = 4'(i);
      coef_wdata = coef_model[i];
      tick();
    end
    coef_we = 1'b0;
    tick();

    //          len  ver done corrupt hs poke mis to
    vecs[0] = '{600, 1'b0, 3, 15, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{600, 1'b0, 1, 15, 1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{77,  1'b1, 2, 15, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5,   1'b1, 1, 4,  0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{9,   1'b0, 0, 15, 0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{10,  1'b0, 1, 15, 0, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 6; k++) begin
      run_job(vecs[k]);
      tick();
    end

    // Reset while tap 6 is on the write channels.
    v = '{600, 1'b0, 0, 15, 0, 1'b0, 1'b0, 1'b0};
    start_job(v);
    waited = 0;
    while (!(awvalid === 1'b1 && awaddr === 12'h038) && waited < 500) begin
      tick();
      waited++;
    end
    chk("rst_tap6_reached", 32'(awvalid === 1'b1 && awaddr === 12'h038), 32'd1);
    chk("rst_writes_before", 32'(wr_idx), 32'd7);
    axis_rst = 1'b1;
    tick();
    chk("midrst_awvalid", 32'(awvalid), 32'd0);
    chk("midrst_wvalid", 32'(wvalid), 32'd0);
    chk("midrst_arvalid", 32'(arvalid), 32'd0);
    chk("midrst_rready", 32'(rready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_wr.delete();
    exp_rd.delete();
    axis_rst = 1'b0;
    tick();

    // Fresh job after reset: must restart at 0x10 with the retained coefficients.
    v = '{600, 1'b1, 1, 15, 0, 1'b0, 1'b0, 1'b0};
    run_job(v);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_axil_host.md
Name: fir_axil_host

Overview:
- AXI4-Lite initiator (master) that drives the FIR accelerator's AXI4-Lite register port from a simple local command interface.
- Sequence per job:
  - write data_length;
  - write Tape_Num tap coefficients;
  - optionally read the taps back and compare;
  - write ap_start;
  - poll ap_ctrl until ap_done.
- Sits between the testbench/host controller and the FIR block; it replaces hand-written AXI-Lite bus tasks.

Parameters:
- pADDR_WIDTH, 12, AXI-Lite address width.
- pDATA_WIDTH, 32, AXI-Lite data width.
- Tape_Num, 11, number of tap coefficients written per job (1..16).
- POLL_GAP, 4, idle cycles between successive ap_ctrl poll reads (>=0).
- POLL_TIMEOUT, 4096, maximum poll reads before abort (>=1).

Ports:
- axis_clk  in  1  clock.
- axis_rst  in  1  reset; synchronous, active-high.
- coef_we  in  1  load strobe for local coefficient store.
- coef_idx  in  4  coefficient index, 0..Tape_Num-1; writes with idx >= Tape_Num are ignored.
- coef_wdata  in  pDATA_WIDTH  coefficient value.
- job_len  in  pDATA_WIDTH  data length, sampled on job_start.
- job_verify  in  1  enable tap readback check, sampled on job_start.
- job_start  in  1  single-cycle request; ignored while busy.
- busy  out  1  high from the cycle after an accepted job_start until the done cycle.
- done  out  1  one-cycle pulse at job end.
- err_mismatch  out  1  sticky; set on readback mismatch; cleared by the next accepted job_start.
- err_timeout  out  1  sticky; set on poll timeout; cleared by the next accepted job_start.
- awvalid  out  1  write-address valid.
- awaddr  out  pADDR_WIDTH  write address.
- awready  in  1  write-address ready.
- wvalid  out  1  write-data valid.
- wdata  out  pDATA_WIDTH  write data.
- wready  in  1  write-data ready.
- arvalid  out  1  read-address valid.
- araddr  out  pADDR_WIDTH  read address.
- arready  in  1  read-address ready.
- rvalid  in  1  read-data valid.
- rdata  in  pDATA_WIDTH  read data.
- rready  out  1  read-data ready.

Behaviour:
- Register map (target):
  - 0x00 ap_ctrl: bit0 ap_start, bit1 ap_done, bit2 ap_idle.
  - 0x10 data_length.
  - 0x20 + 4*i tap[i].
- Reset (axis_rst=1 at a clock edge):
  - Outputs: all valids, rready, busy, done, err_* go to 0; awaddr/araddr/wdata go to 0.
  - FSM goes to IDLE.
  - Coefficient store is NOT reset.
  - Reset mid-transaction abandons the bus transfer immediately; valids drop the next cycle.
- Coefficient store: Tape_Num x pDATA_WIDTH registers.
  - coef_we writes at the clock edge in any state.
  - A write during a job affects only taps not yet issued.
- Write transaction:
  - awvalid and wvalid assert together in the same cycle, with stable awaddr/wdata.
  - Each valid is held until its own ready is seen high at a clock edge, then dropped independently.
  - The transaction completes when both handshakes are done, in either order or the same cycle.
  - There is no B channel.
  - The next transaction starts no earlier than the cycle after completion.
- Read transaction:
  - arvalid is held until arready.
  - rready asserts the cycle after the AR handshake and is held until rvalid.
  - rdata is captured on the rvalid&rready edge.
- FSM states: IDLE, WR_LEN, WR_TAP, RD_TAP, WR_START, POLL_GAP, POLL_RD, FINISH.
  - IDLE:
    - On job_start, latch job_len and job_verify, clear err_*, set tap index=0, go to WR_LEN.
    - busy=1 from the next cycle.
  - WR_LEN: write job_len to 0x10 -> WR_TAP.
  - WR_TAP: write coef[idx] to 0x20+4*idx.
    - After the last tap: -> RD_TAP if verify (idx reset to 0), else -> WR_START.
  - RD_TAP: read 0x20+4*idx and compare with coef[idx].
    - On mismatch, set err_mismatch.
    - Checking continues through all taps.
    - After the last tap -> WR_START, regardless of mismatch.
  - WR_START: write 0x0000_0001 to 0x00 -> POLL_GAP.
  - POLL_GAP: count POLL_GAP idle cycles -> POLL_RD; 0 means go directly.
  - POLL_RD: read 0x00.
    - If rdata[1]=1 -> FINISH.
    - Else if the poll count reaches POLL_TIMEOUT, set err_timeout -> FINISH.
    - Else -> POLL_GAP.
  - FINISH: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Tap address arithmetic:
  - 0x20 + (idx<<2), truncated to pADDR_WIDTH.
  - idx counter is 4 bits and never exceeds Tape_Num-1.
- Poll counter: width clog2(POLL_TIMEOUT+1); saturates at POLL_TIMEOUT.
- job_start while busy: ignored, with no side effects.
- job_start in the FINISH cycle: ignored; it is accepted only in IDLE.
- No back-to-back job without passing through IDLE (at least one cycle).

Decomposition:
- Shared package fir_axil_pkg:
  - register offsets (ADDR_AP_CTRL=0x00, ADDR_DATA_LEN=0x10, ADDR_TAP_BASE=0x20);
  - ap_ctrl bit positions (AP_START=0, AP_DONE=1, AP_IDLE=2);
  - FSM state enum.
- One sub-module: axil_master_xact. It performs a single write or read transaction: a req/ack port on the inside, the AXI-Lite master channels on the outside. The sequencer FSM lives in the top module.

Test Plan:
- Zero-wait slave (ready the cycle after valid), Tape_Num=11, coef[i]=i-5, job_len=600, verify=0 -> 13 writes in order: 0x10=600, 0x20..0x48 = -5..5, 0x00=1. Then polling. Slave returns ap_ctrl=0x6 on the 3rd poll -> done pulse, busy low, err_*=0.
- Independent handshakes: awready 3 cycles before wready on tap 0; wready 2 cycles before awready on tap 1; same-cycle on tap 2 -> each write issued exactly once, and the next write starts only after both handshakes.
- Verify path: slave returns tap[4]=0xDEAD instead of -1 -> err_mismatch=1, all 11 readbacks still performed, ap_start still written, done pulses.
- Timeout: POLL_TIMEOUT=8, ap_done never set -> exactly 8 reads of 0x00, err_timeout=1, done pulse. The next job_start clears err_timeout.
- Reset mid-WR_TAP (idx=6, awvalid high) -> the next cycle all valids, busy=0. The coefficient store is retained. A fresh job rewrites from 0x10.
- job_start pulsed while busy, and coef_we idx=12 -> no effect on the sequence or the store.
